// File: rtl/kyber_client_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : kyber_client_pkg                                            |
// | Purpose  : Shared source indices, coefficient width, arbiter state     |
// |            type and the 3-way round-robin pick function used by the    |
// |            NTT source arbiter and the hash ififo scheduler.            |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package kyber_client_pkg;

  localparam int SRC_FIFO0 = 0;  // sampler FIFO0, uniform/matrix coefficients
  localparam int SRC_FIFO1 = 1;  // sampler FIFO1, CBD noise coefficients
  localparam int SRC_DEC   = 2;  // decode FIFO, unpacked pk/ct coefficients
  localparam int COEF_W    = 25;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Returns the first requesting index at or after ptr, wrapping 2 -> 0.
  // With ptr = 0 this degenerates to fixed priority (lowest index wins).
  // Returns 0 when nothing requests; callers qualify with |req.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = 2'd0;
    // Scan farthest-first so the nearest requester is the last to overwrite.
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_src_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ntt_src_rr_pick                                             |
// | Purpose  : Combinational 3-way round-robin / fixed-priority picker.    |
// | Ports    : req   - per-source request vector                           |
// |            ptr   - round-robin start index (0..2)                      |
// |            rr_en - 1 = round-robin from ptr, 0 = fixed priority        |
// |            grant - winning source index                                |
// |            any   - at least one source requests                        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ntt_src_rr_pick
  import kyber_client_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic       rr_en,
  output logic [1:0] grant,
  output logic       any
);

  assign grant = rr_pick(req, rr_en ? ptr : 2'd0);
  assign any   = |req;

endmodule
`default_nettype wire

// File: rtl/ntt_src_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ntt_src_arbiter                                             |
// | Purpose  : Grants one of three coefficient FIFOs per polynomial burst, |
// |            issues read strobes and forwards a single registered        |
// |            valid/data/last/source stream to the NTT core.              |
// | Ports    : src_en/src_empty/src_rd - per-source enable, empty, read    |
// |            src0/1/2_dout           - FIFO head data (24/25/24 bit)     |
// |            flush                   - abandon burst, back to IDLE       |
// |            dst_ready               - core accepts a word issued now    |
// |            dst_valid/data/src/last - registered output stream          |
// |            busy                    - arbiter not IDLE                  |
// | Option   : NTT_ARB_STALL_CNT_EN adds cnt_clr, stall_cnt and bp_cnt.    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ntt_src_arbiter
  import kyber_client_pkg::*;
#(
  parameter int BURST_LEN     = 256,
  parameter int CNT_W         = 8,
  parameter bit RR_EN_DEFAULT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        src_en,
  input  logic [2:0]        src_empty,
  output logic [2:0]        src_rd,
  input  logic [23:0]       src0_dout,
  input  logic [24:0]       src1_dout,
  input  logic [23:0]       src2_dout,
  input  logic              flush,
  input  logic              dst_ready,
  output logic              dst_valid,
  output logic [COEF_W-1:0] dst_data,
  output logic [1:0]        dst_src,
  output logic              dst_last,
  output logic              busy
`ifdef NTT_ARB_STALL_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bp_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  arb_state_t        r_state;
  logic [1:0]        r_grant;
  logic [1:0]        r_rr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rr_en;

  logic [2:0]        w_req;
  logic [1:0]        w_pick;
  logic              w_any;
  logic              w_empty_g;
  logic [COEF_W-1:0] w_dout;
  logic              w_rd;
  logic              w_last;

  assign w_req = src_en & ~src_empty;

  ntt_src_rr_pick u_pick (
    .req   (w_req),
    .ptr   (r_rr_ptr),
    .rr_en (r_rr_en),
    .grant (w_pick),
    .any   (w_any)
  );

  // Route the granted source's empty flag and head data.
  always_comb begin
    w_empty_g = 1'b1;
    w_dout    = '0;
    case (r_grant)
      2'(SRC_FIFO0): begin w_empty_g = src_empty[SRC_FIFO0]; w_dout = COEF_W'(src0_dout); end
      2'(SRC_FIFO1): begin w_empty_g = src_empty[SRC_FIFO1]; w_dout = COEF_W'(src1_dout); end
      2'(SRC_DEC):   begin w_empty_g = src_empty[SRC_DEC];   w_dout = COEF_W'(src2_dout); end
      default: ;
    endcase
  end

  // Reads happen only in BURST; rst gating keeps the FIFOs untouched
  // while the arbiter is being reset mid-burst.
  assign w_rd   = ~rst & ~flush & (r_state == BURST) & dst_ready & ~w_empty_g;
  assign w_last = (r_cnt == LAST_IDX);
  assign src_rd = w_rd ? (3'b001 << r_grant) : 3'b000;
  assign busy   = (r_state == BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= 2'd0;
      r_rr_ptr  <= 2'd0;
      r_cnt     <= '0;
      r_rr_en   <= RR_EN_DEFAULT;
      dst_valid <= 1'b0;
      dst_data  <= '0;
      dst_src   <= 2'd0;
      dst_last  <= 1'b0;
    end else begin
      // Output stage: one register behind the read strobe. Data and
      // source tag only load on a read so the bus stays quiet between words.
      dst_valid <= w_rd;
      dst_last  <= w_rd & w_last;
      if (w_rd) begin
        dst_data <= w_dout;
        dst_src  <= r_grant;
      end

      if (flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_any) begin
              r_grant <= w_pick;
              r_cnt   <= '0;
              r_state <= BURST;
            end
          end
          BURST: begin
            if (w_rd) begin
              r_cnt <= r_cnt + 1'b1;
              if (w_last) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_rr_ptr <= (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef NTT_ARB_STALL_CNT_EN
  // Saturating diagnostics: source starvation vs. core backpressure.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= 16'd0;
      bp_cnt    <= 16'd0;
    end else if (r_state == BURST) begin
      if (dst_ready && w_empty_g && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (!dst_ready && (bp_cnt != 16'hFFFF))                bp_cnt    <= bp_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_src_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_ntt_src_arbiter                                          |
// | Purpose  : Self-checking bench for ntt_src_arbiter: queue-based FIFO   |
// |            environment, burst-level reference model, directed bursts   |
// |            followed by randomized traffic.                             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_ntt_src_arbiter;

  localparam int BL = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_en;
  logic [2:0]  src_empty;
  logic [2:0]  src_rd;
  logic [23:0] src0_dout;
  logic [24:0] src1_dout;
  logic [23:0] src2_dout;
  logic        flush;
  logic        dst_ready;
  logic        dst_valid;
  logic [24:0] dst_data;
  logic [1:0]  dst_src;
  logic        dst_last;
  logic        busy;
`ifdef NTT_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] bp_cnt;
`endif

  always #5 clk = ~clk;

  ntt_src_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .src_en    (src_en),
    .src_empty (src_empty),
    .src_rd    (src_rd),
    .src0_dout (src0_dout),
    .src1_dout (src1_dout),
    .src2_dout (src2_dout),
    .flush     (flush),
    .dst_ready (dst_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_src   (dst_src),
    .dst_last  (dst_last),
    .busy      (busy)
`ifdef NTT_ARB_STALL_CNT_EN
    ,
    .cnt_clr   (1'b0),
    .stall_cnt (stall_cnt),
    .bp_cnt    (bp_cnt)
`endif
  );

  // Stimulus knobs
  bit [2:0] en_v, hold_v;
  bit       rdy_v, fl_v, rs_v, chk_en;

  // FIFO contents (head at index 0)
  logic [24:0] fq [3][$];

  // Reference model: owner = granted source or -1 when idle,
  // done = words read in the current burst.
  int          m_owner = -1;
  int          m_done  = 0;
  int          m_ptr   = 0;
  bit          m_rr    = 1'b1;
  bit          m_valid = 1'b0;
  logic [24:0] m_data  = '0;
  int          m_src   = 0;
  bit          m_last  = 1'b0;
  int          grant_log[$];
  int          valid_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int s, input int n, input bit ctr);
    logic [24:0] v;
    for (int i = 0; i < n; i++) begin
      v = ctr ? 25'(i) : 25'($urandom);
      if (s != 1) v[24] = 1'b0;
      fq[s].push_back(v);
    end
  endtask

  task automatic step();
    logic [2:0]  emp;
    logic [2:0]  erd;
    logic [24:0] h;
    int          c, start;
    @(negedge clk);
    for (int i = 0; i < 3; i++) emp[i] = hold_v[i] || (fq[i].size() == 0);
    rst       = rs_v;
    src_en    = en_v;
    src_empty = emp;
    dst_ready = rdy_v;
    flush     = fl_v;
    h = (fq[0].size() > 0) ? fq[0][0] : 25'h0; src0_dout = h[23:0];
    h = (fq[1].size() > 0) ? fq[1][0] : 25'h0; src1_dout = h;
    h = (fq[2].size() > 0) ? fq[2][0] : 25'h0; src2_dout = h[23:0];
    #1;
    erd = 3'b000;
    if (!rs_v && !fl_v && m_owner >= 0 && rdy_v && !emp[m_owner]) erd[m_owner] = 1'b1;
    if (chk_en) begin
      chk("src_rd",    32'(src_rd),    32'(erd));
      chk("dst_valid", 32'(dst_valid), 32'(m_valid));
      chk("dst_last",  32'(dst_last),  32'(m_last));
      chk("dst_data",  32'(dst_data),  32'(m_data));
      chk("dst_src",   32'(dst_src),   32'(m_src));
      chk("busy",      32'(busy),      32'(m_owner >= 0));
    end
    @(posedge clk);
    if (rs_v) begin
      m_owner = -1; m_done = 0; m_ptr = 0;
      m_valid = 1'b0; m_data = '0; m_src = 0; m_last = 1'b0;
    end else begin
      m_valid = (erd != 3'b000);
      m_last  = 1'b0;
      if (m_valid) begin
        m_data = fq[m_owner].pop_front();
        m_src  = m_owner;
        m_last = (m_done == BL - 1);
        m_done++;
        valid_cnt++;
      end
      if (fl_v) begin
        m_owner = -1; m_done = 0;
      end else if (m_owner < 0) begin
        start = m_rr ? m_ptr : 0;
        for (int k = 0; k < 3; k++) begin
          c = (start + k) % 3;
          if (en_v[c] && !emp[c]) begin
            m_owner = c; m_done = 0; grant_log.push_back(c);
            break;
          end
        end
      end else if (m_done == BL) begin
        m_ptr = (m_owner + 1) % 3;
        m_owner = -1; m_done = 0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  gl_n;
    bit  seen;
    rs_v = 1'b1; en_v = 3'b000; hold_v = 3'b000; rdy_v = 1'b1; fl_v = 1'b0; chk_en = 1'b0;
    step();                 // DUT outputs unknown until first reset edge
    chk_en = 1'b1;
    step();                 // reset state: everything zero
    rs_v = 1'b0;

    // T1: only FIFO1 holds a polynomial
    grant_log.delete(); valid_cnt = 0;
    fill(1, BL, 1'b0); en_v = 3'b111;
    repeat (BL + 4) step();
    chk("t1_words", 32'(valid_cnt), 32'(BL));
    chk("t1_grants", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() > 0) chk("t1_src", 32'(grant_log[0]), 32'd1);

    // T2: all sources full, round-robin from a fresh reset
    rs_v = 1'b1; step(); rs_v = 1'b0;
    grant_log.delete();
    fill(0, 2 * BL, 1'b0); fill(1, BL, 1'b0); fill(2, BL, 1'b0);
    repeat (4 * (BL + 1) + 6) step();
    chk("t2_grants", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk($sformatf("t2_order%0d", k), 32'(grant_log[k]), 32'(k % 3));

    // T3: FIFO0 counter pattern, starved for 5 cycles after word 100
    valid_cnt = 0; en_v = 3'b001;
    fill(0, BL, 1'b1);
    for (int i = 0; i < 400 && !(m_owner == 0 && m_done == 100); i++) step();
    chk("t3_reach100", 32'(m_done), 32'd100);
    hold_v = 3'b001; repeat (5) step(); hold_v = 3'b000;
    repeat (BL) step();
    chk("t3_words", 32'(valid_cnt), 32'(BL));
    chk("t3_drained", 32'(fq[0].size()), 32'd0);

    // T4: decode burst under 1010 backpressure, all-ones first word
    en_v = 3'b100; seen = 1'b0;
    fq[2].push_back(25'h0FFFFFF); fill(2, BL - 1, 1'b0);
    for (int i = 0; i < 2 * BL + 20; i++) begin
      rdy_v = ~rdy_v;
      step();
      if (m_valid && !seen) begin
        seen = 1'b1;
        #2;
        chk("t4_zext", 32'(dst_data), 32'h00FFFFFF);
      end
    end
    rdy_v = 1'b1;
    chk("t4_drained", 32'(fq[2].size()), 32'd0);

    // T5: flush at word 50, regrant follows unchanged pointer (0)
    en_v = 3'b111;
    fill(0, BL, 1'b0); fill(1, BL, 1'b0); fill(2, BL, 1'b0);
    for (int i = 0; i < 200 && !(m_owner >= 0 && m_done == 50); i++) step();
    chk("t5_reach50", 32'(m_done), 32'd50);
    gl_n = grant_log.size();
    fl_v = 1'b1; step(); fl_v = 1'b0;
    for (int i = 0; i < 10 && grant_log.size() == gl_n; i++) step();
    chk("t5_regrant_seen", 32'(grant_log.size() > gl_n), 32'd1);
    chk("t5_regrant", 32'(grant_log[$]), 32'd0);

    // T6: reset at word 10, next grant starts at src0
    for (int i = 0; i < 200 && !(m_owner >= 0 && m_done == 10); i++) step();
    chk("t6_reach10", 32'(m_done), 32'd10);
    rs_v = 1'b1; step(); rs_v = 1'b0;
    gl_n = grant_log.size();
    for (int i = 0; i < 10 && grant_log.size() == gl_n; i++) step();
    chk("t6_regrant_seen", 32'(grant_log.size() > gl_n), 32'd1);
    chk("t6_regrant", 32'(grant_log[$]), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en_v   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
      rdy_v  = ($urandom_range(0, 3) != 0);
      hold_v = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      fl_v   = ($urandom_range(0, 299) == 0);
      rs_v   = ($urandom_range(0, 999) == 0);
      for (int s = 0; s < 3; s++)
        if (fq[s].size() < 20 && $urandom_range(0, 3) == 0) fill(s, 40, 1'b0);
      step();
    end
    rs_v = 1'b0; fl_v = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_src_arbiter.md
Name: ntt_src_arbiter

Overview:
Shares the single coefficient input of the client NTT core among three source FIFOs: the sampler FIFO0 (24-bit, uniform/matrix coefficients), the sampler FIFO1 (25-bit, CBD noise coefficients) and the decode FIFO (24-bit, unpacked public-key/ciphertext coefficients). It grants one source per polynomial burst and issues FIFO read strobes. It realigns data to the 1-cycle FIFO read latency and presents a single valid/data/last stream plus a source tag to the NTT core. It replaces the ad-hoc registered-request mux in the client top level.

Parameters:
BURST_LEN, 256, words per grant (one polynomial); legal values are 2..256.
CNT_W, 8, width of the burst counter; must satisfy 2^CNT_W >= BURST_LEN.
RR_EN_DEFAULT, 1, reset value of the round-robin mode bit (0 = fixed priority src0 > src1 > src2).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
src_en  in  3  per-source request enable from the top-level FSM; bit i gates source i
src_empty  in  3  FIFO empty flags; bit0 = FIFO0, bit1 = FIFO1, bit2 = decode FIFO
src_rd  out  3  one-hot FIFO read strobes
src0_dout  in  24  FIFO0 read data
src1_dout  in  25  FIFO1 read data
src2_dout  in  24  decode FIFO read data
flush  in  1  abandon the current burst and return to IDLE
dst_ready  in  1  NTT core can take a word issued this cycle
dst_valid  out  1  dst_data valid this cycle
dst_data  out  25  coefficient; 24-bit sources are zero-extended
dst_src  out  2  source index of dst_data (0, 1 or 2)
dst_last  out  1  final word of the burst
busy  out  1  high when not IDLE

Behaviour:
- Reset: state = IDLE, rr_ptr = 0, burst_cnt = 0, and all outputs are 0 (src_rd, dst_valid, dst_data, dst_src, dst_last, busy). Reset mid-burst discards the in-flight word: dst_valid is 0 in the cycle after rst.
- Request vector: req[i] = src_en[i] & ~src_empty[i].
- FSM IDLE:
  - If req is non-zero, choose the winner and go to BURST.
  - Round-robin picks the first requesting index starting at rr_ptr, wrapping 2 -> 0. Fixed priority picks the lowest requesting index.
  - Latch the grant, clear burst_cnt, assert busy from the next cycle.
  - IDLE issues no read in the same cycle as the decision.
- FSM BURST:
  - src_rd[g] = dst_ready & ~src_empty[g] & ~flush. Source g is locked for the whole burst; no pre-emption.
  - Each read increments burst_cnt.
  - The read issued at burst_cnt == BURST_LEN-1 is tagged last. The FSM returns to IDLE in the next cycle and rr_ptr becomes g+1 (mod 3).
  - If the source goes empty mid-burst: hold the grant, issue no read, no timeout.
  - If src_en[g] deasserts mid-burst: the burst continues; src_en is sampled only in IDLE.
- Output pipeline:
  - One register stage: dst_valid(t+1) = |src_rd(t); dst_src(t+1) = g; dst_last(t+1) = last tag(t); dst_data(t+1) = selected FIFO dout, zero-extended.
  - Latency from read strobe to dst_valid is exactly 1 cycle.
- Backpressure: dst_ready is sampled only at issue time. The NTT core must accept the single word already in flight after it drops dst_ready; there is no skid buffer.
- Flush:
  - Synchronous and wins over everything except rst.
  - No src_rd in the flush cycle. The FSM goes to IDLE next cycle, burst_cnt clears, rr_ptr is unchanged.
  - A word issued the cycle before flush is still delivered, with dst_last = 0.
- Simultaneous events: if the last word and a new request coincide, the new grant is decided in the IDLE cycle. This gives exactly one bubble between bursts.

Optional Feature:
Macro: NTT_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits): counts BURST cycles where dst_ready & src_empty[g], saturating at 0xFFFF.
  - Adds output bp_cnt (16 bits): counts BURST cycles with ~dst_ready, saturating at 0xFFFF.
  - Both counters clear on rst and on the input cnt_clr, which is also added.
- Undefined: neither the ports nor the logic exist; all other behaviour is identical.

Decomposition:
- Shared package kyber_client_pkg holds:
  - SRC_FIFO0 = 0, SRC_FIFO1 = 1, SRC_DEC = 2;
  - COEF_W = 25;
  - arb_state_t {IDLE, BURST};
  - the function rr_pick(req, ptr).
- One sub-module is natural: ntt_src_rr_pick. It is a combinational 3-way round-robin/priority picker, reused by the hash ififo scheduler.

Test Plan:
1. Only FIFO1 non-empty with 256 words, src_en = 3'b111, dst_ready = 1 -> src_rd = 3'b010 for 256 consecutive cycles after 1 idle cycle; dst_valid 256 cycles lagging by 1; dst_last on word 256; dst_src = 1.
2. All three sources full, round-robin -> burst order 0, 1, 2, 0; exactly one dst_valid = 0 bubble between bursts.
3. FIFO0 empties after word 100 for 5 cycles -> no src_rd for those 5 cycles; burst resumes; dst_last still on word 256, with no duplicated or dropped word (check against a data counter pattern).
4. dst_ready toggles 1010... during a decode burst -> dst_valid only in cycles following ready=1; 24-bit data 0xFFFFFF appears as 25'h0FFFFFF.
5. flush at burst word 50 -> no read in the flush cycle; word 50 delivered with dst_last = 0; busy = 0 next cycle; the next grant follows the unchanged rr_ptr.
6. rst asserted at word 10 of a burst -> next cycle all outputs are 0; the FSM is in IDLE; a subsequent grant starts at src0.
